// File: rtl/spike_raster_fifo.sv
// spike_raster_fifo: captures per-millisecond population rasters as whole frames and
// streams them out as 16-bit words. Optional FRAME_STAMP_EN prepends a frame-count header word.
module spike_raster_fifo #(
  parameter int unsigned DEPTH_FRAMES = 16,
  parameter int unsigned POP_W        = 128,
  parameter int unsigned WORD_W       = 16
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          clear,
  input  logic                          frame_tick,
  input  logic [POP_W-1:0]              population,
  input  logic                          rd_en,
  output logic [WORD_W-1:0]             rd_data,
  output logic [15:0]                   words_avail,
  output logic [$clog2(DEPTH_FRAMES):0] frames_stored,
  output logic                          full,
  output logic                          empty,
  output logic [15:0]                   drop_count,
  output logic                          underflow
);

`ifdef FRAME_STAMP_EN
  localparam int unsigned WPF = POP_W / WORD_W + 1;
`else
  localparam int unsigned WPF = POP_W / WORD_W;
`endif
  localparam int unsigned FRAME_W = WPF * WORD_W;
  localparam int unsigned AW      = $clog2(DEPTH_FRAMES);
  localparam int unsigned IW      = $clog2(WPF + 1);
  localparam logic [AW:0] DEPTH_CNT = DEPTH_FRAMES[AW:0];
  localparam logic [IW-1:0] LAST_WORD = IW'(WPF - 1);

  logic [FRAME_W-1:0] mem [DEPTH_FRAMES];
  logic [FRAME_W-1:0] frame_in;
  logic [FRAME_W-1:0] head_frame;
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [IW-1:0]      word_idx;
  logic               capture;
  logic               drop;
  logic               rd_ok;
  logic               rd_under;
  logic               frame_done;

`ifdef FRAME_STAMP_EN
  logic [15:0] frame_cnt;

  // Counts every tick, dropped or not, so the host sees gaps as stamp jumps.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)        frame_cnt <= '0;
    else if (clear)      frame_cnt <= '0;
    else if (frame_tick) frame_cnt <= frame_cnt + 16'd1;
  end

  assign frame_in = {population, frame_cnt};
`else
  assign frame_in = population;
`endif

  // Fullness and emptiness are taken from the registered count, i.e. pre-cycle.
  always_comb begin
    full       = (frames_stored == DEPTH_CNT);
    empty      = (frames_stored == '0);
    capture    = frame_tick && !full && !clear;
    drop       = frame_tick && full && !clear;
    rd_ok      = rd_en && !empty && !clear;
    rd_under   = rd_en && empty && !clear;
    frame_done = rd_ok && (word_idx == LAST_WORD);
    head_frame = mem[rd_ptr];
  end

  assign words_avail = 16'(frames_stored) * 16'(WPF) - 16'(word_idx);

  always_ff @(posedge clk) begin
    if (capture) mem[wr_ptr] <= frame_in;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      word_idx      <= '0;
      frames_stored <= '0;
      rd_data       <= '0;
      drop_count    <= '0;
      underflow     <= 1'b0;
    end else if (clear) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      word_idx      <= '0;
      frames_stored <= '0;
      rd_data       <= '0;
      drop_count    <= '0;
      underflow     <= 1'b0;
    end else begin
      if (capture) wr_ptr <= wr_ptr + 1'b1;
      if (drop && drop_count != '1) drop_count <= drop_count + 16'd1;

      if (rd_ok) begin
        rd_data <= head_frame[int'(word_idx)*WORD_W +: WORD_W];
        if (frame_done) begin
          word_idx <= '0;
          rd_ptr   <= rd_ptr + 1'b1;
        end else begin
          word_idx <= word_idx + 1'b1;
        end
      end else if (rd_under) begin
        rd_data   <= '0;
        underflow <= 1'b1;
      end

      // Capture and frame completion in the same cycle cancel out.
      if (capture && !frame_done)      frames_stored <= frames_stored + 1'b1;
      else if (frame_done && !capture) frames_stored <= frames_stored - 1'b1;
    end
  end

endmodule

// File: tb/tb_spike_raster_fifo.sv
// Randomized self-checking bench for spike_raster_fifo against a word-queue reference model.
module tb_spike_raster_fifo;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned POPW  = 128;
`ifdef FRAME_STAMP_EN
  localparam int unsigned WPF = POPW / 16 + 1;
`else
  localparam int unsigned WPF = POPW / 16;
`endif

  logic            clk = 1'b0;
  logic            reset_n;
  logic            clear;
  logic            frame_tick;
  logic [POPW-1:0] population;
  logic            rd_en;
  logic [15:0]     rd_data;
  logic [15:0]     words_avail;
  logic [4:0]      frames_stored;
  logic            full;
  logic            empty;
  logic [15:0]     drop_count;
  logic            underflow;

  spike_raster_fifo #(.DEPTH_FRAMES(DEPTH), .POP_W(POPW), .WORD_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .clear(clear), .frame_tick(frame_tick),
    .population(population), .rd_en(rd_en), .rd_data(rd_data),
    .words_avail(words_avail), .frames_stored(frames_stored), .full(full),
    .empty(empty), .drop_count(drop_count), .underflow(underflow)
  );

  always #5 clk = ~clk;

  int unsigned tests_run    = 0;
  int unsigned tests_failed = 0;

  // Reference: a flat queue of readable words; frames are whole groups of WPF words.
  logic [15:0] mq[$];
  logic [15:0] m_rd;
  logic [15:0] m_drop;
  logic        m_uf;
  logic [15:0] m_stamp;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int unsigned m_frames();
    return (mq.size() + WPF - 1) / WPF;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_rd = '0; m_drop = '0; m_uf = 1'b0; m_stamp = '0;
  endtask

  task automatic model_step(input logic tk, input logic [POPW-1:0] pop, input logic rd,
                            input logic clr);
    bit full_pre, empty_pre;
    if (clr) begin
      model_reset();
      return;
    end
    full_pre  = (m_frames() == DEPTH);
    empty_pre = (mq.size() == 0);
    if (rd) begin
      if (empty_pre) begin
        m_rd = '0;
        m_uf = 1'b1;
      end else begin
        m_rd = mq.pop_front();
      end
    end
    if (tk) begin
      if (full_pre) begin
        if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
      end else begin
`ifdef FRAME_STAMP_EN
        mq.push_back(m_stamp);
`endif
        for (int unsigned k = 0; k < POPW / 16; k++) mq.push_back(pop[16*k +: 16]);
      end
      m_stamp = m_stamp + 16'd1;
    end
  endtask

  task automatic check_outputs(input string ph);
    int unsigned fs;
    fs = m_frames();
    check_eq({ph, ".rd_data"},       32'(rd_data),       32'(m_rd));
    check_eq({ph, ".words_avail"},   32'(words_avail),   32'(mq.size()));
    check_eq({ph, ".frames_stored"}, 32'(frames_stored), fs);
    check_eq({ph, ".full"},          32'(full),          32'(fs == DEPTH));
    check_eq({ph, ".empty"},         32'(empty),         32'(mq.size() == 0));
    check_eq({ph, ".drop_count"},    32'(drop_count),    32'(m_drop));
    check_eq({ph, ".underflow"},     32'(underflow),     32'(m_uf));
  endtask

  task automatic cycle(input string ph, input logic tk, input logic [POPW-1:0] pop,
                       input logic rd, input logic clr);
    frame_tick = tk; population = pop; rd_en = rd; clear = clr;
    @(posedge clk);
    model_step(tk, pop, rd, clr);
    #1;
    check_outputs(ph);
    frame_tick = 1'b0; rd_en = 1'b0; clear = 1'b0;
  endtask

  function automatic logic [POPW-1:0] rand_pop();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    reset_n = 1'b0; clear = 1'b0; frame_tick = 1'b0; rd_en = 1'b0; population = '0;
    model_reset();
    #12;
    check_outputs("reset");
    reset_n = 1'b1;

    // Single frame with ascending words.
    cycle("single_cap", 1'b1, 128'h0007_0006_0005_0004_0003_0002_0001_0000, 1'b0, 1'b0);
    for (int unsigned i = 0; i < WPF; i++) cycle("single_rd", 1'b0, '0, 1'b1, 1'b0);

    // Empty read: sticky underflow until clear.
    cycle("empty_rd", 1'b0, '0, 1'b1, 1'b0);
    cycle("empty_hold", 1'b0, '0, 1'b0, 1'b0);
    cycle("empty_clr", 1'b0, '0, 1'b0, 1'b1);

    // Overflow: 20 ticks into a 16-frame buffer, then read the head word.
    for (int unsigned i = 0; i < 20; i++) cycle("ovf_cap", 1'b1, rand_pop(), 1'b0, 1'b0);
    cycle("ovf_rd", 1'b0, '0, 1'b1, 1'b0);
    // Finish the head frame while a tick arrives on its last word: still dropped.
    for (int unsigned i = 1; i < WPF - 1; i++) cycle("full_rd", 1'b0, '0, 1'b1, 1'b0);
    cycle("full_tick_rd", 1'b1, rand_pop(), 1'b1, 1'b0);

    // frames_stored=3, tick plus frame-completing read keeps it at 3.
    cycle("c3_clr", 1'b0, '0, 1'b0, 1'b1);
    for (int unsigned i = 0; i < 3; i++) cycle("c3_cap", 1'b1, rand_pop(), 1'b0, 1'b0);
    for (int unsigned i = 0; i < WPF - 1; i++) cycle("c3_rd", 1'b0, '0, 1'b1, 1'b0);
    cycle("c3_both", 1'b1, rand_pop(), 1'b1, 1'b0);

    // Asynchronous reset in the middle of a frame read.
    cycle("ar_rd", 1'b0, '0, 1'b1, 1'b0);
    cycle("ar_rd", 1'b0, '0, 1'b1, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    check_outputs("async_reset");
    @(negedge clk) reset_n = 1'b1;
    cycle("ar_cap", 1'b1, rand_pop(), 1'b0, 1'b0);
    for (int unsigned i = 0; i < WPF; i++) cycle("ar_rdout", 1'b0, '0, 1'b1, 1'b0);

    // Clear coinciding with a tick captures nothing.
    cycle("clr_tick", 1'b1, rand_pop(), 1'b0, 1'b1);

    // Randomized traffic, alternating fill-heavy and drain-heavy phases.
    for (int unsigned i = 0; i < 4000; i++) begin
      logic tk, rd, clr;
      if ((i / 200) % 2 == 0) begin
        tk = ($urandom_range(99) < 45);
        rd = ($urandom_range(99) < 30);
      end else begin
        tk = ($urandom_range(99) < 10);
        rd = ($urandom_range(99) < 85);
      end
      clr = ($urandom_range(499) == 0);
      cycle("rand", tk, rand_pop(), rd, clr);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
